fetch_stage: RTL

- Instruction fetch stage of the 5-stage RISC-V pipeline; producer end of the InstrD/PC_DE interface that the decode stage consumes.
- Holds the PC and issues in-order requests to instruction memory over a request/grant/response handshake.
- Buffers returned instructions in a small queue and presents one instruction per cycle in a fetch/decode output register.
- Handles decode stalls and branch redirects; a redirect discards stale in-flight fetches.

---
 rtl/fetch_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage of a 5-stage RISC-V pipeline. It holds the PC and
// issues in-order requests to instruction memory. Returned words go into a
// small {PC, instr} queue and are handed to decode one per cycle through the
// InstrD / PC_DE / VALID_D output register. A taken branch redirects the PC,
// flushes the queue and discards every fetch that is still in flight.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   IMEM_REQ     fetch request valid
//   IMEM_ADDR    fetch address (word aligned)
//   IMEM_GNT     memory accepted the request this cycle
//   IMEM_RVALID  response valid (in request order, >= 1 cycle after issue)
//   IMEM_RDATA   returned instruction word
//   STALL_D      decode cannot accept; output register holds
//   BRN_TAKEN    single-cycle redirect request
//   BRN_TARGET   redirect PC (bits [1:0] ignored)
//   InstrD       instruction to decode (NOP when no valid instruction)
//   PC_DE        PC of InstrD
//   VALID_D      InstrD / PC_DE hold a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        STALL_D,
  input  logic        BRN_TAKEN,
  input  logic [31:0] BRN_TARGET,
  output logic [31:0] InstrD,
  output logic [31:0] PC_DE,
  output logic        VALID_D
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [31:0]   instr_q;
  logic [31:0]   pc_de_q;
  logic          valid_q;

  logic [CW:0]   in_use;
  logic          issue;
  logic          resp_ok;
  logic          q_empty;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [31:0]   resp_pc;
  logic          unused_target_bits;

  assign unused_target_bits = ^BRN_TARGET[1:0];

  // Request credit: fetches in flight plus buffered words may never exceed
  // the queue depth, so every accepted response always has somewhere to go.
  // No new fetch is issued while stale responses are still being drained or
  // while a redirect is being taken.
  assign in_use    = (CW+1)'(outstanding) + (CW+1)'(count);
  assign IMEM_REQ  = rst && !BRN_TAKEN && (drop_cnt == '0) &&
                     (in_use < (CW+1)'(QDEPTH));
  assign IMEM_ADDR = pc;
  assign issue     = IMEM_REQ && IMEM_GNT;

  // Responses come back in order and no fetch is issued while stale ones
  // drain, so the PC of the oldest live fetch is simply the current PC
  // minus one word per outstanding request. This avoids a separate PC FIFO.
  assign resp_pc = pc - (32'(outstanding) << 2);

  // Response routing: a live response either bypasses straight into the
  // output register (queue empty and decode ready) or is pushed into the
  // queue. A redirect in the same cycle discards it.
  assign resp_ok = IMEM_RVALID && (drop_cnt == '0) && !BRN_TAKEN;
  assign q_empty = (count == '0);
  assign bypass  = resp_ok && q_empty && !STALL_D;
  assign push    = resp_ok && !bypass;
  assign pop     = !BRN_TAKEN && !STALL_D && !q_empty;

  // PC and fetch bookkeeping. On a redirect all live fetches become stale:
  // they move into drop_cnt (minus the one returning this very cycle) and
  // the live outstanding count restarts at zero for the new target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (BRN_TAKEN) begin
      pc          <= {BRN_TARGET[31:2], 2'b00};
      outstanding <= '0;
      drop_cnt    <= drop_cnt + outstanding - CW'(IMEM_RVALID);
    end else begin
      if (issue) begin
        pc <= pc + 32'd4;
      end
      outstanding <= outstanding + CW'(issue) - CW'(resp_ok);
      if (IMEM_RVALID && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Queue storage. Only the pointers need a reset; the data is qualified by
  // the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]    <= resp_pc;
      q_instr[tail] <= IMEM_RDATA;
    end
  end

  // Queue pointers and occupancy. Push and pop in the same cycle leave the
  // occupancy unchanged; a redirect flushes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (BRN_TAKEN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Fetch/decode output register. A redirect forces the bubble even when
  // decode is stalled. The bubble keeps the previous PC_DE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP;
      pc_de_q <= 32'h0;
      valid_q <= 1'b0;
    end else if (BRN_TAKEN) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (!STALL_D) begin
      if (!q_empty) begin
        instr_q <= q_instr[head];
        pc_de_q <= q_pc[head];
        valid_q <= 1'b1;
      end else if (bypass) begin
        instr_q <= IMEM_RDATA;
        pc_de_q <= resp_pc;
        valid_q <= 1'b1;
      end else begin
        instr_q <= NOP;
        valid_q <= 1'b0;
      end
    end
  end

  assign InstrD  = instr_q;
  assign PC_DE   = pc_de_q;
  assign VALID_D = valid_q;

  // A response arriving while the queue is full means the memory broke the
  // credit protocol; the word would otherwise be lost silently.
  no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count == DEPTH_C)));

endmodule
